// File: rtl/hram_arb_pkg.sv
// Shared constants for the two-port HyperRAM/PSRAM arbiter.
package hram_arb_pkg;

  // Arbiter FSM encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ISSUE    = 2'd1;
  localparam logic [1:0] ST_WAIT_RDY = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  // Default abort limit (cycles in WAIT_RDY) and data returned on abort
  localparam int          TIMEOUT_DEF  = 1023;
  localparam logic [31:0] ERR_DATA_DEF = 32'hFFFF_FFFF;

  // Width of the WAIT_RDY cycle counter
  localparam int CNT_W = 10;

  // Port indices into one-hot grant vectors; port 0 is the CPU, port 1 DMA/video
  localparam int PORT0 = 0;
  localparam int PORT1 = 1;

endpackage

// File: rtl/hram_arb_rr.sv
// Two-way round-robin pick: on a tie the port that was not served last wins.
module hram_arb_rr
  import hram_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] winner
);

  // last=1 means port 1 was served last, so port 0 takes a tie
  always_comb begin
    winner = valid;
    if (valid[PORT0] && valid[PORT1]) begin
      winner = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/hram_arb.sv
// Two-port arbiter in front of a PSRAM controller. One access in flight at a
// time; request fields are captured at grant so the controller sees a stable
// request regardless of what the requester does afterwards.
module hram_arb
  import hram_arb_pkg::*;
#(
  parameter int          TIMEOUT  = TIMEOUT_DEF,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
)
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        p0_valid,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_wstrb,
  output logic [31:0] p0_rdata,
  output logic        p0_ready,
  input  logic        p1_valid,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_wstrb,
  output logic [31:0] p1_rdata,
  output logic        p1_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [1:0]  gnt,
  output logic        timeout_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             last_owner;
  logic [1:0]       winner;

  hram_arb_rr u_rr (
    .valid  ({p1_valid, p0_valid}),
    .last   (last_owner),
    .winner (winner)
  );

  // Main FSM: grant and capture, issue, wait for completion or timeout, then
  // hold off the next grant until the controller has dropped mem_ready
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      last_owner  <= 1'(PORT1);
      gnt         <= 2'b00;
      mem_valid   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
      p0_ready    <= 1'b0;
      p1_ready    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      p0_ready <= 1'b0;
      p1_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!mem_ready && (winner != 2'b00)) begin
            gnt   <= winner;
            state <= ST_ISSUE;
            if (winner[PORT0]) begin
              mem_addr  <= p0_addr;
              mem_wdata <= p0_wdata;
              mem_wstrb <= p0_wstrb;
            end else begin
              mem_addr  <= p1_addr;
              mem_wdata <= p1_wdata;
              mem_wstrb <= p1_wstrb;
            end
          end
        end
        ST_ISSUE: begin
          mem_valid <= 1'b1;
          wait_cnt  <= '0;
          state     <= ST_WAIT_RDY;
        end
        ST_WAIT_RDY: begin
          if (mem_ready || (wait_cnt == CNT_LAST)) begin
            mem_valid <= 1'b0;
            state     <= ST_RELEASE;
            if (!mem_ready) begin
              timeout_err <= 1'b1;
            end
            if (gnt[PORT0]) begin
              p0_rdata   <= mem_ready ? mem_rdata : ERR_DATA;
              p0_ready   <= 1'b1;
              last_owner <= 1'(PORT0);
            end else begin
              p1_rdata   <= mem_ready ? mem_rdata : ERR_DATA;
              p1_ready   <= 1'b1;
              last_owner <= 1'(PORT1);
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          if (!mem_ready) begin
            gnt   <= 2'b00;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hram_arb.sv
// Scoreboard bench for hram_arb: a negedge-driven PSRAM responder, directed
// stimulus that queues expected requests/responses, and a monitor that pops
// and compares whenever the DUT launches a request or pulses ready.
module tb_hram_arb;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct packed {
    logic [1:0]  rdy;
    logic [31:0] rdata;
  } resp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        p0_valid, p1_valid;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic [3:0]  p0_wstrb, p1_wstrb;
  logic [31:0] p0_rdata, p1_rdata;
  logic        p0_ready, p1_ready;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [1:0]  gnt;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  int ready_count = 0;

  req_t  req_q[$];
  resp_t resp_q[$];

  // Responder configuration
  bit          resp_en   = 1'b1;
  bit          resp_echo = 1'b0;
  int          resp_delay = 1;
  int          resp_hold  = 0;
  logic [31:0] resp_data  = 32'h0;

  hram_arb #(.TIMEOUT(16), .ERR_DATA(32'hFFFF_FFFF)) dut (
    .clk(clk), .resetn(resetn),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb),
    .p0_rdata(p0_rdata), .p0_ready(p0_ready),
    .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb),
    .p1_rdata(p1_rdata), .p1_ready(p1_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .gnt(gnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic report_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got timeout, want event", name);
  endtask

  task automatic apply_stimulus(input int port, input logic valid, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb);
    if (port == 0) begin
      p0_valid = valid; p0_addr = addr; p0_wdata = wdata; p0_wstrb = wstrb;
    end else begin
      p1_valid = valid; p1_addr = addr; p1_wdata = wdata; p1_wstrb = wstrb;
    end
  endtask

  task automatic wait_gnt(input int budget);
    int n = 0;
    while (gnt == 2'b00 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (gnt == 2'b00) report_fail("wait_gnt");
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(gnt == 2'b00 && !mem_valid && !mem_ready) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(gnt == 2'b00 && !mem_valid && !mem_ready)) report_fail("wait_idle");
  endtask

  task automatic wait_mem_valid(input int budget);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!mem_valid && n < budget);
    if (!mem_valid) report_fail("wait_mem_valid");
  endtask

  // PSRAM controller model: raise mem_ready after resp_delay cycles of
  // mem_valid, hold it until mem_valid falls plus resp_hold extra cycles
  initial begin
    int wait_cnt = 0;
    int hold_cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        mem_ready = 1'b0; wait_cnt = 0; hold_cnt = 0;
      end else if (mem_valid && !mem_ready) begin
        if (resp_en) begin
          wait_cnt++;
          if (wait_cnt >= resp_delay) begin
            mem_ready = 1'b1;
            mem_rdata = resp_echo ? ~mem_addr : resp_data;
            wait_cnt  = 0;
          end
        end
      end else if (!mem_valid && mem_ready) begin
        if (hold_cnt >= resp_hold) begin
          mem_ready = 1'b0; hold_cnt = 0;
        end else begin
          hold_cnt++;
        end
      end
    end
  end

  // Monitor: compare each launched request and each ready pulse with the queues
  initial begin
    logic  prev_mv = 1'b0;
    logic  prev_rdy = 1'b0;
    logic  stable_bad = 1'b0;
    req_t  cap, er;
    resp_t rr;
    cap = '0;
    forever begin
      @(posedge clk); #1;
      if (!resetn) begin
        prev_mv = 1'b0; prev_rdy = 1'b0; stable_bad = 1'b0;
      end else begin
        if (mem_valid && !prev_mv) begin
          cap = {gnt, mem_addr, mem_wdata, mem_wstrb};
          stable_bad = 1'b0;
          if (req_q.size() == 0) report_fail("unexpected_req");
          else begin
            er = req_q.pop_front();
            check_output("mem_req", 128'(cap), 128'(er));
          end
        end else if (mem_valid && prev_mv) begin
          if ({gnt, mem_addr, mem_wdata, mem_wstrb} !== cap) stable_bad = 1'b1;
        end else if (!mem_valid && prev_mv) begin
          check_output("mem_stable", 128'(stable_bad), 128'(1'b0));
        end
        if (p0_ready || p1_ready) begin
          ready_count++;
          if (resp_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected_ready: got %b%b, want none", p1_ready, p0_ready);
          end else begin
            rr = resp_q.pop_front();
            check_output("ready_resp",
                         {p1_ready, p0_ready, (p0_ready ? p0_rdata : p1_rdata), mem_valid, prev_rdy},
                         {rr.rdy, rr.rdata, 1'b0, 1'b0});
          end
        end
        prev_mv  = mem_valid;
        prev_rdy = p0_ready | p1_ready;
      end
    end
  end

  initial begin
    int n;
    resetn = 1'b0;
    apply_stimulus(0, 1'b0, 32'h0, 32'h0, 4'h0);
    apply_stimulus(1, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset state
    repeat (3) @(negedge clk);
    check_output("rst_ctrl", {mem_valid, p0_ready, p1_ready, gnt, timeout_err}, 6'b0);
    check_output("rst_mem", {mem_addr, mem_wdata, mem_wstrb}, 68'h0);
    check_output("rst_rdata", {p0_rdata, p1_rdata}, 64'h0);
    resetn = 1'b1;
    @(negedge clk);

    // p0 read, controller answers after 5 cycles; p0 drops valid after grant
    resp_delay = 5; resp_data = 32'hDEAD_BEEF;
    req_q.push_back('{2'b01, 32'h100, 32'h0, 4'h0});
    resp_q.push_back('{2'b01, 32'hDEAD_BEEF});
    apply_stimulus(0, 1'b1, 32'h100, 32'h0, 4'h0);
    wait_gnt(10);
    @(negedge clk);
    p0_valid = 1'b0;
    wait_idle(40);
    repeat (2) @(negedge clk);
    check_output("p0_rdata_hold", p0_rdata, 32'hDEAD_BEEF);
    check_output("p1_rdata_untouched", p1_rdata, 32'h0);

    // p1 partial write: strobes and data must reach the controller unchanged
    resp_delay = 3; resp_data = 32'h0BAD_F00D;
    req_q.push_back('{2'b10, 32'h40, 32'h1234_5678, 4'b0011});
    resp_q.push_back('{2'b10, 32'h0BAD_F00D});
    apply_stimulus(1, 1'b1, 32'h40, 32'h1234_5678, 4'b0011);
    wait_gnt(10);
    @(negedge clk);
    p1_valid = 1'b0;
    wait_idle(40);

    // Round robin from reset with both ports requesting continuously
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    resp_delay = 1; resp_echo = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        req_q.push_back('{2'b01, 32'h200, 32'h0, 4'h0});
        resp_q.push_back('{2'b01, 32'hFFFF_FDFF});
      end else begin
        req_q.push_back('{2'b10, 32'h300, 32'h0, 4'h0});
        resp_q.push_back('{2'b10, 32'hFFFF_FCFF});
      end
    end
    n = ready_count;
    apply_stimulus(0, 1'b1, 32'h200, 32'h0, 4'h0);
    apply_stimulus(1, 1'b1, 32'h300, 32'h0, 4'h0);
    for (int k = 0; k < 200 && ready_count < n + 4; k++) @(negedge clk);
    p0_valid = 1'b0;
    p1_valid = 1'b0;
    if (ready_count < n + 4) report_fail("rr_four_accesses");
    wait_idle(40);

    // Controller keeps mem_ready high 3 cycles after mem_valid falls
    resp_hold = 3;
    for (int i = 0; i < 2; i++) begin
      req_q.push_back('{2'b10, 32'h700, 32'h0, 4'h0});
      resp_q.push_back('{2'b10, 32'hFFFF_F8FF});
    end
    apply_stimulus(1, 1'b1, 32'h700, 32'h0, 4'h0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!p1_ready && n < 40);
    if (!p1_ready) report_fail("hold_first_ready");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_output("hold_no_regrant", {mem_valid, gnt}, {1'b0, 2'b10});
    end
    @(posedge clk); #1;
    check_output("hold_release", gnt, 2'b00);
    @(posedge clk); #1;
    check_output("hold_regrant", gnt, 2'b10);
    @(negedge clk);
    p1_valid = 1'b0;
    wait_idle(40);
    resp_hold = 0;

    // Controller never answers: abort after 16 WAIT_RDY cycles
    resp_en = 1'b0;
    req_q.push_back('{2'b01, 32'h500, 32'h0, 4'h0});
    resp_q.push_back('{2'b01, 32'hFFFF_FFFF});
    apply_stimulus(0, 1'b1, 32'h500, 32'h0, 4'h0);
    wait_mem_valid(10);
    p0_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!p0_ready && n < 40);
    check_output("timeout_cycles", n, 16);
    check_output("timeout_err_set", timeout_err, 1'b1);
    wait_idle(40);

    // Reset in the middle of an access: immediate drop, no ready pulse
    req_q.push_back('{2'b10, 32'h600, 32'h0, 4'h0});
    apply_stimulus(1, 1'b1, 32'h600, 32'h0, 4'h0);
    wait_mem_valid(10);
    p1_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("timeout_err_sticky", timeout_err, 1'b1);
    resetn = 1'b0;
    #1;
    check_output("midrst_outputs", {mem_valid, gnt, p0_ready, p1_ready, timeout_err}, 5'b0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    check_output("midrst_quiet", {mem_valid, gnt, p0_ready, p1_ready}, 4'b0);

    check_output("req_q_empty", req_q.size(), 0);
    check_output("resp_q_empty", resp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute bound in case a wait is ever bypassed
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, want finish");
    $fatal(1, "[TB] global timeout");
  end

endmodule
